// File: rtl/reg_file_scrub_if.sv
// Register file access bundle: decode read addresses, writeback
// write port, scrub request and status.
interface reg_file_scrub_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] WriteData;
  logic            RegWrite;
  logic            clr;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic            busy;
  logic            wr_drop;

  modport master (
    output rs1, rs2, rd, WriteData, RegWrite, clr,
    input  ReadData1, ReadData2, busy, wr_drop
  );

  modport slave (
    input  rs1, rs2, rd, WriteData, RegWrite, clr,
    output ReadData1, ReadData2, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_scrub.sv
// Integer register file with hardwired x0, optional write bypass
// and a one-register-per-cycle scrub engine after reset or clr.
module reg_file_scrub #(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input logic             clk,
  input logic             reset,
  reg_file_scrub_if.slave bus
);
  localparam int NREGS = 1 << AW;

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic            busy_q;
  logic            drop_q;
  logic [XLEN-1:0] regs [NREGS];
  logic            req;
  logic            wen;
  logic            byp;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  assign req = bus.RegWrite && (bus.rd != '0);
  assign wen = (state == IDLE) && req && !bus.clr;
  assign byp = (BYPASS != 0) && !busy_q && req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SCRUB;
      idx    <= '0;
      busy_q <= 1'b1;
      drop_q <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.clr) begin
            state  <= SCRUB;
            idx    <= '0;
            busy_q <= 1'b1;
            drop_q <= req;
          end
        end
        SCRUB: begin
          drop_q <= req;
          idx    <= idx + 1'b1;
          if (idx == AW'(NREGS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= SCRUB;
      endcase
    end
  end

  // Storage has no reset; the scrub walk is what clears it.
  always_ff @(posedge clk) begin
    if (state == SCRUB) begin
      regs[idx] <= '0;
    end else if (wen) begin
      regs[bus.rd] <= bus.WriteData;
    end
  end

  always_comb begin
    rd1 = regs[bus.rs1];
    unique case (1'b1)
      busy_q || (bus.rs1 == '0):  rd1 = '0;
      byp && (bus.rs1 == bus.rd): rd1 = bus.WriteData;
      default: ;
    endcase
  end

  always_comb begin
    rd2 = regs[bus.rs2];
    unique case (1'b1)
      busy_q || (bus.rs2 == '0):  rd2 = '0;
      byp && (bus.rs2 == bus.rd): rd2 = bus.WriteData;
      default: ;
    endcase
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;
  assign bus.busy      = busy_q;
  assign bus.wr_drop   = drop_q;
endmodule

// File: tb/tb_reg_file_scrub.sv
// Bench for reg_file_scrub: BYPASS=1 and BYPASS=0 instances share
// stimulus; vector table, corner sequences and a random phase.
module tb_reg_file_scrub;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_scrub_if #(.XLEN(64), .AW(5)) bus1 ();
  reg_file_scrub_if #(.XLEN(64), .AW(5)) bus0 ();

  assign bus0.rs1       = bus1.rs1;
  assign bus0.rs2       = bus1.rs2;
  assign bus0.rd        = bus1.rd;
  assign bus0.WriteData = bus1.WriteData;
  assign bus0.RegWrite  = bus1.RegWrite;
  assign bus0.clr       = bus1.clr;

  reg_file_scrub #(.XLEN(64), .AW(5), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  reg_file_scrub #(.XLEN(64), .AW(5), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  // Reference: a scrub is "all registers are zero, busy for 32 more edges".
  logic [63:0] mem [32];
  int          left = 32;
  logic        drop = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      left = 32;
      drop = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end else begin
      if (left > 0) begin
        drop = bus1.RegWrite && (bus1.rd != 0);
        left = left - 1;
      end else if (bus1.clr) begin
        drop = bus1.RegWrite && (bus1.rd != 0);
        left = 32;
        for (int i = 0; i < 32; i++) mem[i] = '0;
      end else begin
        drop = 1'b0;
        if (bus1.RegWrite && bus1.rd != 0) mem[bus1.rd] = bus1.WriteData;
      end
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (left > 0 || a == 0) return 64'h0;
    if (byp && bus1.RegWrite && bus1.rd != 0 && a == bus1.rd)
      return bus1.WriteData;
    return mem[a];
  endfunction

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all();
    logic b;
    b = (left > 0);
    cmp("m_busy1", {63'b0, bus1.busy}, {63'b0, b});
    cmp("m_busy0", {63'b0, bus0.busy}, {63'b0, b});
    cmp("m_drop1", {63'b0, bus1.wr_drop}, {63'b0, drop});
    cmp("m_drop0", {63'b0, bus0.wr_drop}, {63'b0, drop});
    cmp("m_rd1_b1", bus1.ReadData1, exp_rd(bus1.rs1, 1'b1));
    cmp("m_rd2_b1", bus1.ReadData2, exp_rd(bus1.rs2, 1'b1));
    cmp("m_rd1_b0", bus0.ReadData1, exp_rd(bus1.rs1, 1'b0));
    cmp("m_rd2_b0", bus0.ReadData2, exp_rd(bus1.rs2, 1'b0));
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] w, input logic [63:0] d,
                       input logic we, input logic c);
    bus1.rs1       = a1;
    bus1.rs2       = a2;
    bus1.rd        = w;
    bus1.WriteData = d;
    bus1.RegWrite  = we;
    bus1.clr       = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_run(input string tag);
    for (int k = 1; k <= 32; k++) begin
      tick();
      drive(5'($urandom), 5'($urandom), 5'd0, 64'h0, 1'b0, 1'b0);
      #3;
      cmp({tag, "_busy"}, {63'b0, bus1.busy}, {63'b0, (k < 32)});
      cmp({tag, "_busy0"}, {63'b0, bus0.busy}, {63'b0, (k < 32)});
      if (k < 32) cmp({tag, "_rd"}, bus1.ReadData1 | bus0.ReadData2, 64'h0);
      chk_all();
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      tick();
      drive(5'(a), 5'(31 - a), 5'd0, 64'h0, 1'b0, 1'b0);
      #3;
      cmp({tag, "_z1"}, bus1.ReadData1, 64'h0);
      cmp({tag, "_z2"}, bus0.ReadData2, 64'h0);
    end
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic        we;
    logic [63:0] e1_b1;
    logic [63:0] e2_b1;
    logic [63:0] e1_b0;
    logic [63:0] e2_b0;
  } vec_t;

  vec_t vt [8];

  localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] AA = 64'hAAAA_5555_AAAA_5555;

  initial begin
    vt[0] = '{5'd0, 5'd0, 5'd5, DB, 1'b1, 0, 0, 0, 0};
    vt[1] = '{5'd5, 5'd5, 5'd0, 0, 1'b0, DB, DB, DB, DB};
    vt[2] = '{5'd0, 5'd5, 5'd0, '1, 1'b1, 0, DB, 0, DB};
    vt[3] = '{5'd0, 5'd0, 5'd0, 0, 1'b0, 0, 0, 0, 0};
    vt[4] = '{5'd7, 5'd7, 5'd7, 64'h1234, 1'b1, 64'h1234, 64'h1234, 0, 0};
    vt[5] = '{5'd7, 5'd5, 5'd0, 0, 1'b0, 64'h1234, DB, 64'h1234, DB};
    vt[6] = '{5'd5, 5'd7, 5'd5, AA, 1'b1, AA, 64'h1234, DB, 64'h1234};
    vt[7] = '{5'd5, 5'd5, 5'd0, 0, 1'b0, AA, AA, AA, AA};

    drive(5'd3, 5'd9, 5'd0, 64'h0, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      #3;
      cmp("rst_busy", {63'b0, bus1.busy}, 64'h1);
      cmp("rst_drop", {63'b0, bus1.wr_drop}, 64'h0);
      cmp("rst_rd", bus1.ReadData1 | bus1.ReadData2, 64'h0);
      chk_all();
    end
    tick();
    reset = 1'b1;
    #3;
    cmp("rel_busy", {63'b0, bus1.busy}, 64'h1);
    busy_run("init");

    for (int i = 0; i < 8; i++) begin
      tick();
      drive(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].wd, vt[i].we, 1'b0);
      #3;
      cmp($sformatf("v%0d_r1_b1", i), bus1.ReadData1, vt[i].e1_b1);
      cmp($sformatf("v%0d_r2_b1", i), bus1.ReadData2, vt[i].e2_b1);
      cmp($sformatf("v%0d_r1_b0", i), bus0.ReadData1, vt[i].e1_b0);
      cmp($sformatf("v%0d_r2_b0", i), bus0.ReadData2, vt[i].e2_b0);
      cmp($sformatf("v%0d_drop", i), {63'b0, bus1.wr_drop}, 64'h0);
    end

    for (int i = 1; i < 32; i++) begin
      tick();
      drive(5'(i - 1), 5'(i), 5'(i), 64'(i), 1'b1, 1'b0);
      #3;
      chk_all();
    end
    tick();
    drive(5'd17, 5'd30, 5'd0, 64'h0, 1'b0, 1'b1);
    #3;
    cmp("fill17", bus1.ReadData1, 64'd17);
    cmp("fill30", bus0.ReadData2, 64'd30);
    tick();
    drive(5'd17, 5'd30, 5'd0, 64'h0, 1'b0, 1'b0);
    #3;
    cmp("clr_busy", {63'b0, bus1.busy}, 64'h1);
    cmp("clr_rd", bus1.ReadData1 | bus0.ReadData2, 64'h0);
    for (int c = 1; c <= 32; c++) begin
      tick();
      drive(5'($urandom), 5'($urandom), 5'(c == 10 ? 3 : 0),
            64'hFF, (c == 10), (c == 5));
      #3;
      cmp("scr_busy", {63'b0, bus1.busy}, {63'b0, (c < 32)});
      if (c == 11) cmp("scr_drop", {63'b0, bus1.wr_drop}, 64'h1);
      if (c == 12) cmp("scr_drop_end", {63'b0, bus0.wr_drop}, 64'h0);
      chk_all();
    end
    read_all_zero("scr");

    tick();
    drive(5'd0, 5'd0, 5'd20, 64'h2020, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 5'd31, 64'h3131, 1'b1, 1'b0);
    tick();
    drive(5'd20, 5'd31, 5'd0, 64'h0, 1'b0, 1'b1);
    #3;
    cmp("pre_x20", bus1.ReadData1, 64'h2020);
    cmp("pre_x31", bus0.ReadData2, 64'h3131);
    tick();
    drive(5'd20, 5'd31, 5'd0, 64'h0, 1'b0, 1'b0);
    repeat (16) tick();
    reset = 1'b0;
    #3;
    cmp("mid_rst_busy", {63'b0, bus1.busy}, 64'h1);
    chk_all();
    tick();
    tick();
    reset = 1'b1;
    busy_run("rst2");
    read_all_zero("rst2");

    for (int n = 0; n < 400; n++) begin
      tick();
      drive(5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
      #3;
      chk_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_scrub.md
Name: reg_file_scrub

Overview:
- Parametrised successor to the core's integer register file: two combinational read ports and one synchronous write port.
- Adds a hardwired-zero x0 and optional write-to-read bypass.
- Adds a sequential scrub engine that zeroes every register one per cycle after reset or on request, with a busy indication.
- Sits between decode (rs1/rs2/rd) and writeback (WriteData/RegWrite) in the datapath.

Parameters:
XLEN, 64, data width of each register in bits
AW, 5, address width; register count NREGS = 2**AW
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = read returns the stored value

Ports:
clk  input  1  clock, all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
rs1  input  AW  read address, port 1
rs2  input  AW  read address, port 2
rd  input  AW  write address
WriteData  input  XLEN  write data
RegWrite  input  1  write enable, sampled on the rising clk edge
clr  input  1  scrub request, sampled on the rising clk edge
ReadData1  output  XLEN  read data, port 1 (combinational)
ReadData2  output  XLEN  read data, port 2 (combinational)
busy  output  1  high while the scrub is in progress
wr_drop  output  1  one-cycle registered pulse: a write was discarded because busy was high

Behaviour:
- Reset is asynchronous and active-low.
  - While reset=0: state=SCRUB, idx=0, busy=1, wr_drop=0, ReadData1=ReadData2=0.
  - Storage contents are not reset directly; the scrub clears them.
- FSM states:
  - IDLE: normal operation, busy=0.
    - clr=1 at an edge -> SCRUB with idx=0.
    - No write is performed at that edge; a write request at that edge is dropped and flagged.
  - SCRUB: busy=1.
    - Each edge writes 0 to Registers[idx], then idx <= idx+1.
    - At the edge where idx=NREGS-1 that register is zeroed, then state -> IDLE; busy falls after that edge.
    - clr during SCRUB is ignored; the scrub does not restart.
- Scrub duration: exactly NREGS edges after the reset release or after the clr edge. AW=5 gives 32 cycles.
- idx is AW bits wide; wrap is impossible because the FSM exits at NREGS-1.
- Reads:
  - Combinational, zero latency.
  - While busy=1, both ports return 0 regardless of address.
  - Address 0 always returns 0.
- Writes:
  - Occur in IDLE only, at the rising edge when RegWrite=1 and rd!=0.
  - rd=0 writes are silently ignored and do not set wr_drop.
- Bypass (BYPASS=1): in IDLE, when RegWrite=1, rd!=0 and rsN==rd, ReadDataN=WriteData in the same cycle. Both ports may bypass simultaneously.
- No bypass (BYPASS=0): the new value is visible on the read ports the cycle after the write edge.
- wr_drop is set for exactly one cycle after any edge where RegWrite=1, rd!=0 and the write was discarded. A write is discarded when state=SCRUB or when the clr edge occurs in IDLE. wr_drop is otherwise 0.
- Reset asserted mid-scrub or mid-operation: immediately returns to SCRUB with idx=0, and the scrub restarts from register 0 after release.
- Arithmetic: no width conversion. WriteData is stored verbatim at XLEN bits.

Test Plan:
- Reset low 3 cycles, then release. Require: busy=1 for exactly 32 edges, ReadData1/2=0 throughout, busy=0 after the 32nd edge, and any rs reads 0.
- IDLE: write rd=5, WriteData=64'hDEAD_BEEF_0123_4567. Next cycle rs1=5, rs2=5. Require both ports = 64'hDEAD_BEEF_0123_4567.
- Write rd=0, WriteData=64'hFFFF_FFFF_FFFF_FFFF, then read rs1=0. Require ReadData1=0 and wr_drop stays 0.
- BYPASS=1: same cycle RegWrite=1, rd=7, WriteData=64'h1234, rs1=7. Require ReadData1=64'h1234 combinationally. Repeat with BYPASS=0: require the old value (0), and 64'h1234 on the next cycle.
- Fill x1..x31 with the value equal to their index. Pulse clr. Require busy for 32 cycles and reads=0 during the scrub. Issue RegWrite rd=3 at scrub cycle 10: require a wr_drop pulse and x3=0 after the scrub. After the scrub all registers read 0.
- Assert reset at scrub cycle 16 (idx=16) for 2 cycles, then release. Require busy for a full 32 further edges and all registers read 0 afterwards.
